// File: rtl/test_ftdi_imit_if.sv
// Handshake and status signals between the FPGA-side USB core (master) and the
// FT600/601 imitator (slave); the bidirectional data/BE bus stays on plain ports.
interface test_ftdi_imit_if;
  logic        oTXE_N;
  logic        oRXF_N;
  logic        iOE_N;
  logic        iRD_N;
  logic        iWR_N;
  logic [1:0]  iGPIO;
  logic        oERR;
  logic [15:0] oERR_CNT;

  modport slave (
    output oTXE_N, oRXF_N, oERR, oERR_CNT,
    input  iOE_N, iRD_N, iWR_N, iGPIO
  );

  modport master (
    input  oTXE_N, oRXF_N, oERR, oERR_CNT,
    output iOE_N, iRD_N, iWR_N, iGPIO
  );
endinterface

// File: rtl/test_ftdi_imit.sv
// FT600/601 245-sync-FIFO imitator: streams an incrementing RX word sequence to
// the FPGA and checks that the FPGA writes back the same incrementing sequence.
module test_ftdi_imit #(
  parameter int DEPTH        = 256,
  parameter int REFILL_DELAY = 16,
  parameter int DRAIN_DELAY  = 16
) (
  input  logic            iCLK,
  input  logic            iRESET,
  output logic            oCLK,
  inout  wire  [31:0]     ioDATA,
  inout  wire  [3:0]      ioBE,
  test_ftdi_imit_if.slave ftdi
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int MAXD = (REFILL_DELAY > DRAIN_DELAY) ? REFILL_DELAY : DRAIN_DELAY;
  localparam int TW   = $clog2(MAXD + 1);

  // state    | meaning
  // TX_INIT  | just out of reset, TX buffer not yet open
  // TX_OPEN  | accepting FPGA writes
  // TX_DRAIN | buffer full, host draining it
  typedef enum logic [1:0] {TX_INIT, TX_OPEN, TX_DRAIN} tx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [31:0]     rx_seq_q, rx_seq_d;
  logic [CW-1:0]   rx_count_q, rx_count_d;
  logic [TW-1:0]   refill_tmr_q, refill_tmr_d;
  logic [31:0]     tx_seq_q, tx_seq_d;
  logic [CW-1:0]   tx_count_q, tx_count_d;
  logic [TW-1:0]   drain_tmr_q, drain_tmr_d;
  logic            err_q, err_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  logic            txe_n;
  logic            rxf_n;
  logic            violation;
  logic            rd_acc;
  logic            wr_acc;
  logic            bus_drive;
  logic            mismatch;
  logic            refill_tc;
  logic            drain_tc;
  logic [31:0]     be_mask;
  logic            gpio_unused;

  assign oCLK        = iCLK;
  assign gpio_unused = ^ftdi.iGPIO;

  assign violation = ~ftdi.iWR_N & ~ftdi.iOE_N;
  assign rxf_n     = (rx_count_q == '0);
  assign rd_acc    = ~ftdi.iOE_N & ~ftdi.iRD_N & ftdi.iWR_N & ~rxf_n;
  assign wr_acc    = ~ftdi.iWR_N & ftdi.iOE_N & ~txe_n;
  assign refill_tc = (refill_tmr_q == TW'(REFILL_DELAY - 1));
  assign drain_tc  = (drain_tmr_q == TW'(DRAIN_DELAY - 1));

  // The bus is released the instant reset rises, independent of the clock.
  assign bus_drive = ~iRESET & ~ftdi.iOE_N & ftdi.iWR_N;
  assign ioDATA    = bus_drive ? rx_seq_q : 'z;
  assign ioBE      = bus_drive ? 4'hF : 'z;

  assign be_mask  = {{8{ioBE[3]}}, {8{ioBE[2]}}, {8{ioBE[1]}}, {8{ioBE[0]}}};
  assign mismatch = |((ioDATA ^ tx_seq_q) & be_mask);

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      tx_state_q <= TX_INIT;
    end else begin
      tx_state_q <= tx_state_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_INIT:  tx_state_d = TX_OPEN;
      TX_OPEN:  if (wr_acc && (tx_count_q == CW'(DEPTH - 1))) tx_state_d = TX_DRAIN;
      TX_DRAIN: if (drain_tc) tx_state_d = TX_OPEN;
      default:  tx_state_d = TX_INIT;
    endcase
  end

  always_comb begin
    txe_n = 1'b1;
    if (tx_state_q == TX_OPEN) txe_n = 1'b0;
  end

  always_comb begin
    rx_seq_d     = rx_seq_q;
    rx_count_d   = rx_count_q;
    refill_tmr_d = refill_tmr_q;
    tx_seq_d     = tx_seq_q;
    tx_count_d   = tx_count_q;
    drain_tmr_d  = drain_tmr_q;
    err_d        = err_q;
    err_cnt_d    = err_cnt_q;

    // rx_seq carries over refills so the stream is continuous.
    if (rd_acc) begin
      rx_seq_d   = rx_seq_q + 32'd1;
      rx_count_d = rx_count_q - CW'(1);
    end else if (rxf_n) begin
      if (refill_tc) begin
        refill_tmr_d = '0;
        rx_count_d   = CW'(DEPTH);
      end else begin
        refill_tmr_d = refill_tmr_q + TW'(1);
      end
    end

    if (wr_acc) begin
      tx_seq_d   = tx_seq_q + 32'd1;
      tx_count_d = tx_count_q + CW'(1);
      if (mismatch) begin
        err_d = 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end
    end

    if (tx_state_q == TX_DRAIN) begin
      if (drain_tc) begin
        drain_tmr_d = '0;
        tx_count_d  = '0;
      end else begin
        drain_tmr_d = drain_tmr_q + TW'(1);
      end
    end

    if (violation) err_d = 1'b1;
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      rx_seq_q     <= '0;
      rx_count_q   <= '0;
      refill_tmr_q <= '0;
      tx_seq_q     <= '0;
      tx_count_q   <= '0;
      drain_tmr_q  <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      rx_seq_q     <= rx_seq_d;
      rx_count_q   <= rx_count_d;
      refill_tmr_q <= refill_tmr_d;
      tx_seq_q     <= tx_seq_d;
      tx_count_q   <= tx_count_d;
      drain_tmr_q  <= drain_tmr_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign ftdi.oTXE_N   = txe_n;
  assign ftdi.oRXF_N   = rxf_n;
  assign ftdi.oERR     = err_q;
  assign ftdi.oERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_test_ftdi_imit.sv
// Bench for the FT600/601 imitator: directed protocol scenarios plus random
// traffic, all checked against a word/buffer-level model of the USB chip.
module tb_test_ftdi_imit;
  localparam int DEPTH  = 256;
  localparam int REFILL = 16;
  localparam int DRAIN  = 16;

  logic        iCLK = 1'b0;
  logic        iRESET;
  logic        oCLK;
  tri1  [31:0] ioDATA;
  tri0  [3:0]  ioBE;
  logic        tb_drv;
  logic [31:0] tb_data;
  logic [3:0]  tb_be;

  assign ioDATA = tb_drv ? tb_data : 'z;
  assign ioBE   = tb_drv ? tb_be : 'z;

  test_ftdi_imit_if bus ();

  test_ftdi_imit #(.DEPTH(DEPTH), .REFILL_DELAY(REFILL), .DRAIN_DELAY(DRAIN)) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .oCLK   (oCLK),
    .ioDATA (ioDATA),
    .ioBE   (ioBE),
    .ftdi   (bus)
  );

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what the USB chip holds, in words and waiting clocks.
  logic [31:0] m_rx_next;
  int          m_rx_avail;
  int          m_rx_wait;
  logic [31:0] m_tx_exp;
  int          m_tx_used;
  bit          m_tx_open;
  int          m_drain_wait;
  bit          m_err;
  int          m_err_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rx_next    = '0;
    m_rx_avail   = 0;
    m_rx_wait    = 0;
    m_tx_exp     = '0;
    m_tx_used    = 0;
    m_tx_open    = 1'b0;
    m_drain_wait = 0;
    m_err        = 1'b0;
    m_err_cnt    = 0;
  endtask

  task automatic model_step(input bit oe_n, input bit rd_n, input bit wr_n,
                            input logic [31:0] d, input logic [3:0] be);
    bit viol;
    bit bad;
    viol = !wr_n && !oe_n;
    if (viol) m_err = 1'b1;
    if (m_rx_avail == 0) begin
      m_rx_wait++;
      if (m_rx_wait == REFILL) begin
        m_rx_avail = DEPTH;
        m_rx_wait  = 0;
      end
    end else if (!oe_n && !rd_n && !viol) begin
      m_rx_next  = m_rx_next + 32'd1;
      m_rx_avail = m_rx_avail - 1;
    end
    if (!m_tx_open) begin
      m_tx_open = 1'b1;
    end else if (m_tx_used == DEPTH) begin
      m_drain_wait++;
      if (m_drain_wait == DRAIN) begin
        m_tx_used    = 0;
        m_drain_wait = 0;
      end
    end else if (!wr_n && oe_n) begin
      bad = 1'b0;
      for (int b = 0; b < 4; b++)
        if (be[b] && (d[b*8 +: 8] != m_tx_exp[b*8 +: 8])) bad = 1'b1;
      if (bad) begin
        m_err = 1'b1;
        if (m_err_cnt < 65535) m_err_cnt++;
      end
      m_tx_exp  = m_tx_exp + 32'd1;
      m_tx_used = m_tx_used + 1;
    end
  endtask

  task automatic check_bus();
    logic [31:0] ed;
    logic [3:0]  eb;
    if (tb_drv) begin
      ed = tb_data;
      eb = tb_be;
    end else if (!iRESET && !bus.iOE_N && bus.iWR_N) begin
      ed = m_rx_next;
      eb = 4'hF;
    end else begin
      ed = '1;
      eb = 4'h0;
    end
    check_val("bus_data", ioDATA, ed);
    check_val("bus_be", {28'd0, ioBE}, {28'd0, eb});
  endtask

  task automatic check_state();
    check_val("rxf_n", {31'd0, bus.oRXF_N}, {31'd0, m_rx_avail == 0});
    check_val("txe_n", {31'd0, bus.oTXE_N}, {31'd0, !(m_tx_open && m_tx_used < DEPTH)});
    check_val("err", {31'd0, bus.oERR}, {31'd0, m_err});
    check_val("err_cnt", {16'd0, bus.oERR_CNT}, 32'(m_err_cnt));
    check_val("oclk", {31'd0, oCLK}, {31'd0, iCLK});
  endtask

  // Called at a falling edge: apply inputs, check the bus, clock, check state.
  task automatic run_cycle(input bit oe_n, input bit rd_n, input bit wr_n,
                           input logic [31:0] d, input logic [3:0] be);
    bus.iOE_N = oe_n;
    bus.iRD_N = rd_n;
    bus.iWR_N = wr_n;
    tb_drv    = !wr_n && oe_n;
    tb_data   = d;
    tb_be     = be;
    #1;
    check_bus();
    @(posedge iCLK);
    model_step(oe_n, rd_n, wr_n, d, be);
    @(negedge iCLK);
    check_state();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b1, 1'b1, 1'b1, 32'h0, 4'h0);
  endtask

  // Reset asserted between clock edges with whatever inputs are applied.
  task automatic pulse_reset();
    #2 iRESET = 1'b1;
    #1;
    model_reset();
    check_state();
    check_bus();
    repeat (2) @(negedge iCLK);
    check_state();
    check_bus();
    iRESET = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iOE_N = 1'b1;
    bus.iRD_N = 1'b1;
    bus.iWR_N = 1'b1;
    bus.iGPIO = 2'b00;
    tb_drv    = 1'b0;
    tb_data   = '0;
    tb_be     = '0;
    iRESET    = 1'b1;
    model_reset();
    repeat (3) @(negedge iCLK);
    check_state();
    check_bus();
    iRESET = 1'b0;

    // Release: TX opens after one clock, first refill after REFILL clocks.
    for (int i = 1; i <= 18; i++) begin
      run_cycle(1'b1, 1'b1, 1'b1, 32'h0, 4'h0);
      if (i == 1)  check_val("txe_after_release", {31'd0, bus.oTXE_N}, 32'd0);
      if (i == 15) check_val("rxf_before_refill", {31'd0, bus.oRXF_N}, 32'd1);
      if (i == 16) check_val("rxf_at_refill", {31'd0, bus.oRXF_N}, 32'd0);
    end

    // Full read burst, reads past empty, then the next refill continues at 256.
    for (int i = 0; i < DEPTH; i++) run_cycle(1'b0, 1'b0, 1'b1, 32'h0, 4'h0);
    check_val("rxf_after_256", {31'd0, bus.oRXF_N}, 32'd1);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 1'b1, 32'h0, 4'h0);
    idle(14);
    run_cycle(1'b0, 1'b1, 1'b1, 32'h0, 4'h0);
    check_val("rx_after_refill", ioDATA, 32'd256);
    check_val("rxf_refilled", {31'd0, bus.oRXF_N}, 32'd0);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b1, 32'h0, 4'h0);

    // Full write burst, dropped writes while full, drain, then continue.
    for (int i = 0; i < DEPTH; i++) run_cycle(1'b1, 1'b1, 1'b0, 32'(i), 4'hF);
    check_val("txe_after_256", {31'd0, bus.oTXE_N}, 32'd1);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 1'b0, 32'hDEAD_0000, 4'hF);
    idle(13);
    check_val("txe_after_drain", {31'd0, bus.oTXE_N}, 32'd0);
    run_cycle(1'b1, 1'b1, 1'b0, 32'd256, 4'hF);
    run_cycle(1'b1, 1'b1, 1'b0, 32'd257, 4'hF);
    check_val("err_clean", {31'd0, bus.oERR}, 32'd0);
    check_val("err_cnt_clean", {16'd0, bus.oERR_CNT}, 32'd0);

    // Mismatch counting and fully masked bytes.
    pulse_reset();
    idle(1);
    run_cycle(1'b1, 1'b1, 1'b0, 32'd0, 4'hF);
    run_cycle(1'b1, 1'b1, 1'b0, 32'd1, 4'hF);
    run_cycle(1'b1, 1'b1, 1'b0, 32'd5, 4'hF);
    run_cycle(1'b1, 1'b1, 1'b0, 32'd3, 4'hF);
    check_val("err_after_bad", {31'd0, bus.oERR}, 32'd1);
    check_val("err_cnt_after_bad", {16'd0, bus.oERR_CNT}, 32'd1);
    run_cycle(1'b1, 1'b1, 1'b0, 32'd7, 4'h0);
    run_cycle(1'b1, 1'b1, 1'b0, 32'd5, 4'hF);
    check_val("err_cnt_masked", {16'd0, bus.oERR_CNT}, 32'd1);

    // Write before TX opens is dropped; then a protocol violation.
    pulse_reset();
    run_cycle(1'b1, 1'b1, 1'b0, 32'h1234_5678, 4'hF);
    run_cycle(1'b1, 1'b1, 1'b0, 32'd0, 4'hF);
    check_val("drop_when_txe_high", {31'd0, bus.oERR}, 32'd0);
    run_cycle(1'b0, 1'b1, 1'b0, 32'd1, 4'hF);
    check_val("err_on_violation", {31'd0, bus.oERR}, 32'd1);

    // Reset in the middle of a read burst restarts the stream at 0.
    pulse_reset();
    idle(16);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0, 1'b1, 32'h0, 4'h0);
    pulse_reset();
    for (int i = 0; i < 18; i++) run_cycle(1'b0, 1'b0, 1'b1, 32'h0, 4'h0);
    check_val("rx_restart", ioDATA, 32'd2);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      int          r;
      logic [31:0] d;
      logic [3:0]  be;
      r  = $urandom_range(0, 99);
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      d  = m_tx_exp;
      if ($urandom_range(0, 19) == 0) d = d ^ (32'd1 << $urandom_range(0, 31));
      if (c == 1500) pulse_reset();
      if (r < 35)      run_cycle(1'b0, 1'b0, 1'b1, 32'h0, 4'h0);
      else if (r < 45) run_cycle(1'b0, 1'b1, 1'b1, 32'h0, 4'h0);
      else if (r < 82) run_cycle(1'b1, 1'b1, 1'b0, d, be);
      else if (r < 84) run_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, d, be);
      else             run_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 32'h0, 4'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/test_ftdi_imit.md
Name: test_ftdi_imit

Overview:
- Synthesizable imitator of an FTDI FT600/601 245-synchronous-FIFO bridge, 32-bit bus, 1 kB buffer per direction.
- Stands in for the USB chip opposite the FPGA USB interface.
- Emits an incrementing 32-bit RX stream and checks that the TX stream written by the FPGA is the same incrementing sequence.

Parameters:
DEPTH, 256, words per buffer (1 kB / 4 bytes).
REFILL_DELAY, 16, clocks between RX buffer empty and next refill.
DRAIN_DELAY, 16, clocks the "host" takes to drain a full TX buffer.

Ports:
iCLK  input  1  sole clock; all logic on its rising edge.
iRESET  input  1  asynchronous, active-high reset.
oCLK  output  1  USB clock to the FPGA; equals iCLK (combinational pass-through, no divider).
ioDATA  inout  32  bidirectional data bus.
ioBE  inout  4  byte enables, bit n qualifies byte n.
oTXE_N  output  1  low = TX buffer can accept FPGA writes.
oRXF_N  output  1  low = RX buffer holds data for the FPGA.
iOE_N  input  1  low = FPGA requests imitator to drive the bus.
iRD_N  input  1  low = FPGA reads (advances RX).
iWR_N  input  1  low = FPGA writes.
iGPIO  input  2  mode select; only 2'b00 (245 mode, single channel) is defined; other values behave as 2'b00.
oERR  output  1  sticky error flag.
oERR_CNT  output  16  TX mismatch count, saturating at 16'hFFFF.

Behaviour:
Reset (async, while iRESET=1):
- rx_seq=0, rx_count=0, refill timer=0.
- tx_seq=0, tx_count=0, drain timer=0.
- oRXF_N=1, oTXE_N=1, oERR=0, oERR_CNT=0.
- Bus undriven (Z).

Bus drive:
- ioDATA=rx_seq and ioBE=4'hF whenever iOE_N=0 and iWR_N=1 (combinational); otherwise both Z.
- With iOE_N=0 and oRXF_N=1 the stale rx_seq is still driven; the FPGA must ignore it.

RX path:
- Read accepted on an edge where iOE_N=0, iRD_N=0 and oRXF_N=0: rx_seq++, rx_count--.
- First valid word is available as soon as OE_N is asserted.
- Each accepted cycle presents the next word in the following cycle.
- rx_count reaching 0 sets oRXF_N=1 at that same edge; no further reads are accepted.
- Reads while oRXF_N=1 are ignored.
- While rx_count=0, the refill timer counts REFILL_DELAY clocks, then sets rx_count=DEPTH and oRXF_N=0 on that edge. rx_seq is not reset, so the stream continues across refills.
- After reset release, the first refill occurs REFILL_DELAY clocks later.
- 32-bit wrap of rx_seq is modular.

TX path:
- oTXE_N goes 0 at the first edge after reset release.
- Write accepted on an edge where iWR_N=0, iOE_N=1 and oTXE_N=0.
  - Word is compared with tx_seq, only bytes whose ioBE bit is 1.
  - On mismatch: oERR=1 and oERR_CNT++ (saturating).
  - tx_seq++ and tx_count++ regardless of match.
- tx_count reaching DEPTH sets oTXE_N=1 at that edge.
- Drain: after DRAIN_DELAY further clocks, tx_count=0 and oTXE_N=0.
- Writes while oTXE_N=1 are dropped: no compare, tx_seq unchanged.

Protocol violation:
- iWR_N=0 and iOE_N=0 on the same edge: write ignored, read ignored, oERR=1.
- The imitator does not drive the bus in this case.

Simultaneous RX and TX activity is otherwise impossible: reads need OE_N low, writes need OE_N high.

Reset mid-transfer:
- Asynchronously aborts everything, restores reset values and releases the bus immediately.
- iRD_N and iWR_N asserted during reset are ignored.

Test Plan:
- Reset release, REFILL_DELAY=16: oTXE_N=0 one clock after release; oRXF_N=0 exactly 16 clocks after release; ioDATA=Z while iOE_N=1.
- iOE_N=0 with iRD_N=0 held for 256 clocks: ioDATA = 0,1,…,255 on consecutive cycles; oRXF_N=1 after the 256th word; next refill after 16 clocks presents 256.
- FPGA writes 256 words 0..255 with BE=F: oTXE_N=1 after word 255; returns to 0 DRAIN_DELAY clocks later; oERR=0, oERR_CNT=0.
- Write words 0,1,5,3 with BE=F: oERR=1, oERR_CNT=1. Word 7 written with BE=4'h0 in place of the expected 4: no error (all bytes masked).
- Write attempted with oTXE_N=1: ignored, tx_seq unchanged. iWR_N=0 together with iOE_N=0: oERR=1, bus stays Z.
- iRESET pulsed mid-read burst: oRXF_N=1, bus Z, rx_seq restarts at 0 after the next refill.
